// File: rtl/seg_disp_pkg.sv
// Shared definitions for the seven-segment digit scanner.
//   DIGIT_W      width of one displayed digit (one hex nibble)
//   slot_state_t phase within a digit slot: GUARD (all digits off) or SHOW
//   DIGIT_OFF    level of an inactive common-anode digit enable (active-low)
package seg_disp_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

    localparam logic DIGIT_OFF = '1;

endpackage

// File: rtl/seg_slot_timer.sv
// Digit slot timer for the scanner.
//   clk, rst_n  clock and asynchronous active-low reset
//   slot_cnt    position inside the current slot, 0 .. REFRESH_DIV-1
//   slot_wrap   high in the last cycle of a slot; the count returns to 0 at the next edge
//   in_guard    high while slot_cnt is inside the leading guard window
module seg_slot_timer #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [$clog2(REFRESH_DIV)-1:0] slot_cnt,
    output logic                           slot_wrap,
    output logic                           in_guard
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] slot_cnt_reg;
    logic [CNT_W-1:0] slot_cnt_next;

    always_comb begin
        slot_wrap     = (slot_cnt_reg == SLOT_LAST);
        slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
        in_guard      = (slot_cnt_reg < GUARD_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_next;
        end
    end

    assign slot_cnt = slot_cnt_reg;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scanner feeding one shared seven-segment decoder.
//   clk, rst_n   clock and asynchronous active-low reset
//   data_in      NUM_DIGITS nibbles to show, nibble 0 is the rightmost digit
//   data_valid   data_in valid; accepted when data_ready is also high
//   data_ready   pending buffer is free
//   lzb_en       blank leading zero digits (digit 0 always shown)
//   nibble_out   nibble for the decoder, changes only at slot starts
//   digit_sel_n  active-low digit enables, at most one low, all high in guard cycles
//   frame_start  one-cycle pulse in the first cycle of the digit-0 slot
// Every output register is loaded with the value belonging to the cycle that
// begins at the same edge, so the outputs line up exactly with slot_cnt and
// digit_idx even though they are registered.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic                          lzb_en,
    output logic [DIGIT_W-1:0]            nibble_out,
    output logic [NUM_DIGITS-1:0]         digit_sel_n,
    output logic                          frame_start
);

    localparam int               DATA_W     = DIGIT_W * NUM_DIGITS;
    localparam int               CNT_W      = $clog2(REFRESH_DIV);
    localparam int               IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt;
    logic             slot_wrap;
    logic             in_guard;

    seg_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_cnt  (slot_cnt),
        .slot_wrap (slot_wrap),
        .in_guard  (in_guard)
    );

    logic [DATA_W-1:0]     display_reg, display_next;
    logic [DATA_W-1:0]     pending_reg;
    logic                  pending_full_reg, pending_full_next;
    logic [IDX_W-1:0]      digit_idx_reg, digit_idx_next;
    logic                  blank_reg, blank_next;
    logic                  data_ready_reg;
    logic [DIGIT_W-1:0]    nibble_out_reg;
    logic [NUM_DIGITS-1:0] digit_sel_n_reg, digit_sel_n_next;
    logic                  frame_start_reg;

    logic                  frame_wrap;
    logic                  commit;
    logic                  transfer;
    slot_state_t           slot_state_next;

    logic [DIGIT_W-1:0]    disp_nib_next [NUM_DIGITS];
    logic [NUM_DIGITS:1]   zero_from;     // nibbles i..NUM_DIGITS-1 of the next display are all zero
    logic [NUM_DIGITS-1:0] digit_blank;   // digit would be blanked with lzb_en set
    logic [NUM_DIGITS-1:0] sel_n_next;    // active-low one-hot of the next digit index

    assign zero_from[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign disp_nib_next[gi] = display_next[gi*DIGIT_W +: DIGIT_W];
            assign sel_n_next[gi]    = (digit_idx_next != IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign zero_from[gi]   = (disp_nib_next[gi] == '0) && zero_from[gi+1];
                assign digit_blank[gi] = zero_from[gi];
            end
        end
    endgenerate

    always_comb begin
        frame_wrap = slot_wrap && (digit_idx_reg == IDX_LAST);
        // pending can only be full while data_ready is low, so commit and transfer are exclusive
        commit     = frame_wrap && pending_full_reg;
        transfer   = data_valid && data_ready_reg;

        digit_idx_next = digit_idx_reg;
        if (slot_wrap) begin
            digit_idx_next = (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
        end

        display_next = commit ? pending_reg : display_reg;

        pending_full_next = pending_full_reg;
        if (commit) begin
            pending_full_next = 1'b0;
        end else if (transfer) begin
            pending_full_next = 1'b1;
        end

        // lzb_en and the display are looked at once per slot, so blanking never changes mid-slot
        blank_next = slot_wrap ? (lzb_en && digit_blank[digit_idx_next]) : blank_reg;

        // The coming cycle is a guard cycle either at a slot start or while still
        // short of the last guard cycle.
        slot_state_next = (slot_wrap || (in_guard && (slot_cnt != GUARD_LAST))) ? GUARD : SHOW;

        digit_sel_n_next = {NUM_DIGITS{DIGIT_OFF}};
        if (slot_state_next == SHOW && !blank_next) begin
            digit_sel_n_next = sel_n_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_reg      <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            digit_idx_reg    <= '0;
            blank_reg        <= 1'b0;
            data_ready_reg   <= 1'b0;
            nibble_out_reg   <= '0;
            digit_sel_n_reg  <= {NUM_DIGITS{DIGIT_OFF}};
            frame_start_reg  <= 1'b0;
        end else begin
            display_reg      <= display_next;
            if (transfer) begin
                pending_reg  <= data_in;
            end
            pending_full_reg <= pending_full_next;
            digit_idx_reg    <= digit_idx_next;
            blank_reg        <= blank_next;
            data_ready_reg   <= !pending_full_next;
            nibble_out_reg   <= disp_nib_next[digit_idx_next];
            digit_sel_n_reg  <= digit_sel_n_next;
            frame_start_reg  <= frame_wrap;
        end
    end

    assign data_ready  = data_ready_reg;
    assign nibble_out  = nibble_out_reg;
    assign digit_sel_n = digit_sel_n_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        lzb_en = 1'b0;
    logic        data_ready;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_sel_n;
    logic        frame_start;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .lzb_en      (lzb_en),
        .nibble_out  (nibble_out),
        .digit_sel_n (digit_sel_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         digit;
        logic [3:0] nib;
        logic [3:0] sel_n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Frame position in cycles, counted from reset release; matches 8*digit_idx + slot_cnt.
    int         ph;
    bit         started;
    logic [3:0] show_nib;
    logic [3:0] show_sel;
    logic       fs_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= 0;
            started <= 1'b0;
        end else begin
            ph      <= (ph + 1) % FRAME;
            started <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at ph=%0d t=%0t", name, act, req, ph, $time);
        end
    endtask

    // Expected frame: nibs holds the four nibbles, sels the four digit_sel_n values {d3,d2,d1,d0}.
    task automatic push_frame(input logic [15:0] nibs, input logic [15:0] sels);
        for (int i = 0; i < ND; i++) begin
            exp_t e;
            e.digit = i;
            e.nib   = nibs[4*i +: 4];
            e.sel_n = sels[4*i +: 4];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: timing rules every cycle, scoreboard compare on the first SHOW cycle of each slot.
    always @(negedge clk) begin
        int   slot;
        exp_t e;
        if (rst_n && started) begin
            slot = ph % RD;
            chk("frame_start_pos", {31'd0, frame_start}, {31'd0, ph == 0});
            chk("frame_start_consec", {31'd0, frame_start && fs_prev}, 32'd0);
            chk("sel_at_most_one", {31'd0, $countones(~digit_sel_n) <= 1}, 32'd1);
            if (slot < BC) begin
                chk("guard_sel", {28'd0, digit_sel_n}, 32'hF);
            end else if (slot == BC) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("slot digit=%0d nibble_out=%h digit_sel_n=%b (want %h %b)",
                             ph / RD, nibble_out, digit_sel_n, e.nib, e.sel_n);
                    chk("slot_digit", ph / RD, e.digit);
                    chk("nibble_out", {28'd0, nibble_out}, {28'd0, e.nib});
                    chk("digit_sel_n", {28'd0, digit_sel_n}, {28'd0, e.sel_n});
                end
                show_nib <= nibble_out;
                show_sel <= digit_sel_n;
            end else begin
                chk("show_hold", {24'd0, nibble_out, digit_sel_n}, {24'd0, show_nib, show_sel});
            end
            fs_prev <= frame_start;
        end else begin
            fs_prev <= 1'b0;
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < FRAME + 8);
        chk("frame_start_seen", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic wait_ph(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ph != target && n < FRAME + 8);
        chk("reach_ph", ph, target);
    endtask

    // Called at a negedge; holds data_valid until accepted, then scrambles data_in.
    task automatic send(input logic [15:0] v, input int bound);
        int n = 0;
        data_in    = v;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("accept", {31'd0, data_ready}, 32'd1);
        $display("transfer data_in=%h at ph=%0d", v, ph);
        @(negedge clk);
        data_valid = 1'b0;
        data_in    = 16'hDEAD;
        chk("ready_drop", {31'd0, data_ready}, 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_nibble", {28'd0, nibble_out}, 32'd0);
        chk("rst_sel", {28'd0, digit_sel_n}, 32'hF);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 16'h7BDE);
        @(negedge clk);
        chk("ready_after_reset", {31'd0, data_ready}, 32'd1);

        // 1: empty display scan
        wait_frame();
        push_frame(16'h0000, 16'h7BDE);

        // 2: mid-frame transfer shows from the next frame only
        wait_ph(10);
        send(16'h1234, 4);
        wait_ph(31);
        chk("ready_before_commit", {31'd0, data_ready}, 32'd0);
        wait_frame();
        push_frame(16'h1234, 16'h7BDE);
        @(negedge clk);
        chk("ready_after_commit", {31'd0, data_ready}, 32'd1);

        // 3: leading-zero blanking, lzb_en changed in the last slot before the boundary
        wait_ph(10);
        send(16'h0050, 4);
        wait_ph(26);
        lzb_en = 1'b1;
        wait_frame();
        push_frame(16'h0050, 16'hFFDE);
        wait_ph(10);
        send(16'h0000, 4);
        wait_ph(26);
        wait_frame();
        push_frame(16'h0000, 16'hFFFE);

        // 4: back-to-back words, the second waits for the first to commit
        wait_ph(10);
        send(16'hAAAA, 4);
        wait_ph(26);
        lzb_en = 1'b0;
        fork
            send(16'hBBBB, 3 * FRAME);
            begin
                wait_frame();
                push_frame(16'hAAAA, 16'h7BDE);
            end
        join
        wait_frame();
        push_frame(16'hBBBB, 16'h7BDE);

        // 5: asynchronous reset in the SHOW part of digit 2 with a word pending
        wait_ph(10);
        send(16'hCCCC, 4);
        wait_ph(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", {28'd0, digit_sel_n}, 32'hF);
        chk("async_rst_nibble", {28'd0, nibble_out}, 32'd0);
        chk("async_rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("async_rst_ready", {31'd0, data_ready}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 16'h7BDE);
        wait_frame();
        push_frame(16'h0000, 16'h7BDE);
        wait_frame();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
